// File: rtl/pwm_pkg.sv
// Shared PWM constants for the LED PWM generator and the duty meter.
// Keeping them in one place stops the two ends from disagreeing.
package pwm_pkg;

  localparam int LEVEL_W     = 8;
  localparam int PERIOD_LOG2 = 8;

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchroniser for an asynchronous line plus rising-edge detect.
// Exposes the synchronised level as well, for high-time counting.
module pwm_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic s2d_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s2d_q <= 1'b0;
    end else begin
      s1_q  <= d_i;
      s2_q  <= s1_q;
      s2d_q <= s2_q;
    end
  end

  assign q_o    = s2_q;
  assign rise_o = s2_q & ~s2d_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// Recovers duty level and period from an external PWM line,
// with period-error and stuck-line flags for 0%/100% duty.
module pwm_duty_meter #(
  parameter int PERIOD_LOG2 = pwm_pkg::PERIOD_LOG2,
  parameter int LEVEL_W     = pwm_pkg::LEVEL_W,
  parameter int CNT_W       = 16,
  parameter int TOL         = 8,
  parameter int TIMEOUT     = 512
) (
  input  logic               clk_25mhz,
  input  logic               reset,
  input  logic               pwm_in,
  output logic [LEVEL_W-1:0] level,
  output logic               level_valid,
  output logic [CNT_W-1:0]   period,
  output logic               period_err,
  output logic               stuck
);

  localparam int NOM   = 1 << PERIOD_LOG2;
  localparam int SHIFT = PERIOD_LOG2 - LEVEL_W;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] P_LO    = CNT_W'(NOM - TOL);
  localparam logic [CNT_W-1:0] P_HI    = CNT_W'(NOM + TOL);
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT - 1);

  localparam logic [LEVEL_W-1:0] LVL_MAX = '1;

  logic s2;
  logic rise;

  pwm_edge_sync u_sync (
    .clk_i  (clk_25mhz),
    .rst_i  (reset),
    .d_i    (pwm_in),
    .q_o    (s2),
    .rise_o (rise)
  );

  logic [CNT_W-1:0]   pcnt_q;
  logic [CNT_W-1:0]   hcnt_q;
  logic [CNT_W-1:0]   pcnt_d;
  logic [CNT_W-1:0]   hcnt_d;
  logic               armed_q;
  logic               stuck_q;
  logic [LEVEL_W-1:0] level_q;
  logic               valid_q;
  logic [CNT_W-1:0]   period_q;
  logic               perr_q;

  logic [CNT_W-1:0]   hsh;
  logic [LEVEL_W-1:0] meas_lvl;
  logic               meas_err;
  logic               timeout;

  assign pcnt_d = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + CNT_W'(1);
  assign hcnt_d = (hcnt_q == CNT_MAX || !s2) ? hcnt_q
                                              : hcnt_q + CNT_W'(1);

  assign hsh      = hcnt_q >> SHIFT;
  assign meas_lvl = (hsh > CNT_W'(LVL_MAX)) ? LVL_MAX
                                            : hsh[LEVEL_W-1:0];
  assign meas_err = (pcnt_q < P_LO) || (pcnt_q > P_HI);

  // Once stuck the counter is past TO_CNT anyway; the guard keeps
  // the single-strobe promise explicit.
  assign timeout = (pcnt_q == TO_CNT) && !stuck_q;

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      pcnt_q   <= '0;
      hcnt_q   <= '0;
      armed_q  <= 1'b0;
      stuck_q  <= 1'b0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      period_q <= '0;
      perr_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (rise) begin
        pcnt_q  <= CNT_W'(1);
        hcnt_q  <= CNT_W'(1);
        armed_q <= 1'b1;
        stuck_q <= 1'b0;
        if (armed_q) begin
          period_q <= pcnt_q;
          level_q  <= meas_lvl;
          perr_q   <= meas_err;
          valid_q  <= 1'b1;
        end
      end else begin
        pcnt_q <= pcnt_d;
        hcnt_q <= hcnt_d;
        if (timeout) begin
          stuck_q  <= 1'b1;
          armed_q  <= 1'b0;
          level_q  <= s2 ? LVL_MAX : '0;
          period_q <= '0;
          perr_q   <= 1'b1;
          valid_q  <= 1'b1;
        end
      end
    end
  end

  assign level       = level_q;
  assign level_valid = valid_q;
  assign period      = period_q;
  assign period_err  = perr_q;
  assign stuck       = stuck_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Bench for pwm_duty_meter: directed table, corner sequences,
// and random PWM checked cycle by cycle against a queue model.
module tb_pwm_duty_meter;

  logic        clk_25mhz = 1'b0;
  logic        reset     = 1'b1;
  logic        pwm_in    = 1'b0;
  logic [7:0]  level;
  logic        level_valid;
  logic [15:0] period;
  logic        period_err;
  logic        stuck;

  int checks = 0;
  int errors = 0;
  int nstrobe = 0;
  bit mon_en = 1'b0;

  pwm_duty_meter dut (
    .clk_25mhz   (clk_25mhz),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .level       (level),
    .level_valid (level_valid),
    .period      (period),
    .period_err  (period_err),
    .stuck       (stuck)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: the synchronised line is kept as a history queue of
  // samples since the last rise; a measurement is just its length and
  // its number of ones.
  int mq[$];
  bit ms1, ms2, ms2d;
  bit m_arm, m_stk, m_perr, m_vld;
  int m_lvl, m_per;

  function automatic int ones();
    int s = 0;
    foreach (mq[i]) s += mq[i];
    return s;
  endfunction

  always @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      mq.delete();
      ms1 = 0; ms2 = 0; ms2d = 0;
      m_arm = 0; m_stk = 0; m_perr = 0; m_vld = 0;
      m_lvl = 0; m_per = 0;
    end else begin
      int d, h;
      m_vld = 0;
      if (ms2 && !ms2d) begin
        if (m_arm) begin
          h = ones();
          d = mq.size() - 256;
          if (d < 0) d = -d;
          m_per  = mq.size();
          m_lvl  = (h > 255) ? 255 : h;
          m_perr = (d > 8);
          m_vld  = 1;
        end
        m_arm = 1;
        m_stk = 0;
        mq.delete();
        mq.push_back(1);
      end else begin
        if (mq.size() == 511 && !m_stk) begin
          m_stk  = 1;
          m_arm  = 0;
          m_lvl  = ms2 ? 255 : 0;
          m_per  = 0;
          m_perr = 1;
          m_vld  = 1;
        end
        mq.push_back(int'(ms2));
      end
      ms2d = ms2;
      ms2  = ms1;
      ms1  = pwm_in;
    end
  end

  always @(negedge clk_25mhz) begin
    if (level_valid === 1'b1) nstrobe++;
    if (!reset && mon_en) begin
      chk("model_valid", level_valid, m_vld);
      chk("model_level", level, m_lvl);
      chk("model_period", period, m_per);
      chk("model_perr", period_err, m_perr);
      chk("model_stuck", stuck, m_stk);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_25mhz);
      #1;
    end
  endtask

  task automatic drive_period(input int p, input int h);
    for (int i = 0; i < p; i++) begin
      pwm_in = (i < h);
      tick(1);
    end
  endtask

  typedef struct {
    int p;
    int h;
    int lvl;
    int per;
    bit perr;
  } vec_t;

  vec_t vt[$];

  initial begin
    int n0;
    vt.push_back('{256,  64,  64, 256, 1'b0});
    vt.push_back('{300, 150, 150, 300, 1'b1});
    vt.push_back('{400, 300, 255, 400, 1'b1});
    vt.push_back('{264, 128, 128, 264, 1'b0});
    vt.push_back('{265, 128, 128, 265, 1'b1});
    vt.push_back('{248, 100, 100, 248, 1'b0});
    vt.push_back('{247, 100, 100, 247, 1'b1});
    vt.push_back('{511, 100, 100, 511, 1'b1});
    vt.push_back('{256, 255, 255, 256, 1'b0});
    for (int k = 1; k < 16; k++)
      vt.push_back('{256, 16 * k, 16 * k, 256, 1'b0});

    // line low from reset: one timeout strobe, level 0
    tick(4);
    reset = 1'b0;
    mon_en = 1'b1;
    n0 = nstrobe;
    pwm_in = 1'b0;
    tick(600);
    @(negedge clk_25mhz);
    chk("low_stuck", stuck, 1);
    chk("low_level", level, 0);
    chk("low_perr", period_err, 1);
    chk("low_period", period, 0);
    chk("low_strobes", nstrobe - n0, 1);
    tick(1);

    foreach (vt[i]) begin
      repeat (3) drive_period(vt[i].p, vt[i].h);
      @(negedge clk_25mhz);
      chk($sformatf("vec%0d_level", i), level, vt[i].lvl);
      chk($sformatf("vec%0d_period", i), period, vt[i].per);
      chk($sformatf("vec%0d_perr", i), period_err, vt[i].perr);
      chk($sformatf("vec%0d_stuck", i), stuck, 0);
      tick(1);
    end

    // strobe three edges after the input rise
    pwm_in = 1'b1;
    @(posedge clk_25mhz); @(negedge clk_25mhz);
    chk("lat_e1", level_valid, 0);
    @(posedge clk_25mhz); @(negedge clk_25mhz);
    chk("lat_e2", level_valid, 0);
    @(posedge clk_25mhz); @(negedge clk_25mhz);
    chk("lat_e3", level_valid, 1);
    chk("lat_level", level, 240);
    tick(1);
    drive_period(252, 60);

    // held high after valid PWM
    drive_period(256, 128);
    pwm_in = 1'b1;
    tick(10);
    n0 = nstrobe;
    tick(590);
    @(negedge clk_25mhz);
    chk("high_stuck", stuck, 1);
    chk("high_level", level, 255);
    chk("high_perr", period_err, 1);
    chk("high_strobes", nstrobe - n0, 1);
    tick(1);

    // reset in the middle of a high phase
    drive_period(256, 128);
    drive_period(256, 128);
    pwm_in = 1'b1;
    tick(50);
    reset = 1'b1;
    #1;
    chk("rst_level", level, 0);
    chk("rst_valid", level_valid, 0);
    chk("rst_period", period, 0);
    chk("rst_perr", period_err, 0);
    chk("rst_stuck", stuck, 0);
    pwm_in = 1'b0;
    tick(4);
    reset = 1'b0;
    tick(20);
    n0 = nstrobe;
    drive_period(256, 128);
    chk("rst_arm_only", nstrobe - n0, 0);
    drive_period(256, 128);
    @(negedge clk_25mhz);
    chk("rst_strobes", nstrobe - n0, 1);
    chk("rst_meas_lvl", level, 128);
    chk("rst_meas_per", period, 256);
    tick(1);

    // random traffic, checked by the model every cycle
    for (int i = 0; i < 40; i++) begin
      int p, h;
      p = $urandom_range(200, 520);
      h = $urandom_range(0, p);
      if (i == 20) begin
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
      end
      drive_period(p, h);
    end
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
